decoder_3x8_pend: RTL and testbench

- Inverse end of the 8-to-3 priority encoder path.
- Accepts an encoded event index (3-bit code plus valid) and produces a registered one-hot pulse.
- Accumulates events into an 8-bit sticky pending register; software/downstream logic clears it bitwise.
- Sits downstream of the encoder as the event-reconstruction/pending stage feeding interrupt-style consumers.

---
 rtl/dec_pkg.sv | 12 +
 rtl/decoder_3x8.sv | 31 +++
 rtl/decoder_3x8_pend.sv | 101 ++++++++++
 tb/tb_decoder_3x8_pend.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared widths, the one-hot event type and the all-pending mask for the
// 3-to-8 event decoder path.
package dec_pkg;

  localparam int N_IN  = 3;
  localparam int N_OUT = 1 << N_IN;

  typedef logic [N_OUT-1:0] onehot_t;

  localparam onehot_t FULL_MASK = {N_OUT{1'b1}};

endpackage

// File: rtl/decoder_3x8.sv
// Purely combinational 3-to-8 decoder with enable; a disabled decoder
// outputs all zeros so its result can be OR-ed straight into state.
module decoder_3x8
  import dec_pkg::*;
(
  input  logic [N_IN-1:0] code,
  input  logic            en,
  output onehot_t         onehot
);

  // Decode the code into a single set bit, or nothing when disabled.
  always_comb begin
    onehot = {N_OUT{1'b0}};
    if (en) begin
      case (code)
        3'd0:    onehot = 8'h01;
        3'd1:    onehot = 8'h02;
        3'd2:    onehot = 8'h04;
        3'd3:    onehot = 8'h08;
        3'd4:    onehot = 8'h10;
        3'd5:    onehot = 8'h20;
        3'd6:    onehot = 8'h40;
        3'd7:    onehot = 8'h80;
        default: onehot = {N_OUT{1'b0}};
      endcase
    end else begin
      onehot = {N_OUT{1'b0}};
    end
  end

endmodule

// File: rtl/decoder_3x8_pend.sv
// Event reconstruction stage: registered one-hot pulse plus sticky pending
// and overflow bits. Define DEC_EVT_CNT_EN to add the saturating event counter.
module decoder_3x8_pend
  import dec_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  code_in,
  input  logic             code_vld,
  output logic             code_rdy,
  output logic [N_OUT-1:0] onehot_out,
  output logic             onehot_vld,
  output logic [N_OUT-1:0] pend,
  input  logic [N_OUT-1:0] clr,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] evt_cnt
);

  onehot_t pend_q, pend_d;
  onehot_t onehot_q, onehot_d;
  logic    onehot_vld_q, onehot_vld_d;
  logic    ovf_q, ovf_d;
  logic    acc_s;
  onehot_t set_s;
  logic    ovf_set_s;

  // Full pending register stalls the producer instead of losing events.
  assign code_rdy = ~(&pend_q);
  assign acc_s    = code_vld & code_rdy;

  decoder_3x8 u_dec (
    .code   (code_in),
    .en     (acc_s),
    .onehot (set_s)
  );

  // Next-state: set wins over clear on pend, and set wins over ovf_clr.
  always_comb begin
    pend_d       = (pend_q & ~clr) | set_s;
    onehot_d     = set_s;
    onehot_vld_d = acc_s;
    ovf_set_s    = |(set_s & pend_q & ~clr);
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= {N_OUT{1'b0}};
      onehot_q     <= {N_OUT{1'b0}};
      onehot_vld_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      onehot_q     <= onehot_d;
      onehot_vld_q <= onehot_vld_d;
      ovf_q        <= ovf_d;
    end
  end

  assign pend       = pend_q;
  assign onehot_out = onehot_q;
  assign onehot_vld = onehot_vld_q;
  assign ovf        = ovf_q;

`ifdef DEC_EVT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of accepted events.
  always_comb begin
    if (acc_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign evt_cnt = cnt_q;
`else
  assign evt_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_decoder_3x8_pend.sv
// Directed self-checking bench for decoder_3x8_pend; counter expectations
// follow DEC_EVT_CNT_EN.
module tb_decoder_3x8_pend;

  logic       clk;
  logic       rst_n;
  logic [2:0] code_in;
  logic       code_vld;
  logic       code_rdy;
  logic [7:0] onehot_out;
  logic       onehot_vld;
  logic [7:0] pend;
  logic [7:0] clr;
  logic       ovf;
  logic       ovf_clr;
  logic [3:0] evt_cnt;

  int checks;
  int errors;
  int acc_total;

  decoder_3x8_pend #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .code_vld   (code_vld),
    .code_rdy   (code_rdy),
    .onehot_out (onehot_out),
    .onehot_vld (onehot_vld),
    .pend       (pend),
    .clr        (clr),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .evt_cnt    (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_cnt();
`ifdef DEC_EVT_CNT_EN
    if (acc_total > 15) return 4'd15;
    return 4'(acc_total);
`else
    return 4'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (onehot_out !== 8'h00) begin errors++; $display("FAIL reset_onehot got %h exp 00", onehot_out); end
    checks++; if (onehot_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", onehot_vld); end
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL reset_pend got %h exp 00", pend); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    checks++; if (code_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", code_rdy); end
    checks++; if (evt_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", evt_cnt); end
  endtask

  task automatic test_single();
    code_in = 3'd5; code_vld = 1'b1;
    tick(); acc_total++;
    code_vld = 1'b0;
    checks++; if (onehot_out !== 8'h20) begin errors++; $display("FAIL single_onehot got %h exp 20", onehot_out); end
    checks++; if (onehot_vld !== 1'b1) begin errors++; $display("FAIL single_vld got %b exp 1", onehot_vld); end
    checks++; if (pend !== 8'h20) begin errors++; $display("FAIL single_pend got %h exp 20", pend); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got %b exp 0", ovf); end
    tick();
    checks++; if (onehot_vld !== 1'b0 || onehot_out !== 8'h00) begin errors++; $display("FAIL single_idle got vld %b out %h exp 0 00", onehot_vld, onehot_out); end
    checks++; if (pend !== 8'h20) begin errors++; $display("FAIL single_sticky got %h exp 20", pend); end
    clr = 8'hFF;
    tick();
    clr = 8'h00;
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL single_clr got %h exp 00", pend); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_oh;
    for (int i = 0; i < 8; i++) begin
      code_in = 3'(i); code_vld = 1'b1;
      #1;
      checks++; if (code_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy code %0d got %b exp 1", i, code_rdy); end
      tick(); acc_total++;
      exp_oh = 8'h01 << i;
      checks++; if (onehot_out !== exp_oh || onehot_vld !== 1'b1) begin errors++; $display("FAIL b2b_pulse code %0d got %h/%b exp %h/1", i, onehot_out, onehot_vld, exp_oh); end
    end
    code_vld = 1'b0;
    #1;
    checks++; if (pend !== 8'hFF) begin errors++; $display("FAIL b2b_pend got %h exp ff", pend); end
    checks++; if (code_rdy !== 1'b0) begin errors++; $display("FAIL b2b_full_rdy got %b exp 0", code_rdy); end
    checks++; if (evt_cnt !== exp_cnt()) begin errors++; $display("FAIL b2b_cnt got %0d exp %0d", evt_cnt, exp_cnt()); end
    code_in = 3'd2; code_vld = 1'b1;
    tick();
    code_vld = 1'b0;
    checks++; if (onehot_vld !== 1'b0 || onehot_out !== 8'h00) begin errors++; $display("FAIL full_ignore_pulse got %b/%h exp 0/00", onehot_vld, onehot_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_ignore_ovf got %b exp 0", ovf); end
    checks++; if (evt_cnt !== exp_cnt()) begin errors++; $display("FAIL full_ignore_cnt got %0d exp %0d", evt_cnt, exp_cnt()); end
  endtask

  task automatic test_full_clear();
    clr = 8'h81;
    tick();
    clr = 8'h00;
    checks++; if (pend !== 8'h7E) begin errors++; $display("FAIL partclr_pend got %h exp 7e", pend); end
    checks++; if (code_rdy !== 1'b1) begin errors++; $display("FAIL partclr_rdy got %b exp 1", code_rdy); end
    clr = 8'hFF;
    tick();
    clr = 8'h00;
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL allclr_pend got %h exp 00", pend); end
  endtask

  task automatic test_overflow();
    code_in = 3'd2; code_vld = 1'b1;
    tick(); acc_total++;
    checks++; if (pend !== 8'h04 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_first got %h/%b exp 04/0", pend, ovf); end
    tick(); acc_total++;
    code_vld = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
    checks++; if (pend !== 8'h04) begin errors++; $display("FAIL ovf_pend got %h exp 04", pend); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    code_in = 3'd2; code_vld = 1'b1; clr = 8'h04;
    tick(); acc_total++;
    code_vld = 1'b0; clr = 8'h00;
    checks++; if (pend !== 8'h04) begin errors++; $display("FAIL setclr_pend got %h exp 04", pend); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL setclr_ovf got %b exp 0", ovf); end
    checks++; if (onehot_vld !== 1'b1 || onehot_out !== 8'h04) begin errors++; $display("FAIL setclr_pulse got %b/%h exp 1/04", onehot_vld, onehot_out); end
  endtask

  task automatic test_ovf_priority();
    code_in = 3'd2; code_vld = 1'b1; ovf_clr = 1'b1;
    tick(); acc_total++;
    code_vld = 1'b0; ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_prio got %b exp 1", ovf); end
    ovf_clr = 1'b1; clr = 8'hFF;
    tick();
    ovf_clr = 1'b0; clr = 8'h00;
    checks++; if (ovf !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL cleanup got %b/%h exp 0/00", ovf, pend); end
  endtask

  task automatic test_counter();
    code_in = 3'd0; code_vld = 1'b1; clr = 8'h01;
    for (int i = 0; i < 20; i++) begin
      tick(); acc_total++;
    end
    code_vld = 1'b0; clr = 8'h00;
    checks++; if (evt_cnt !== exp_cnt()) begin errors++; $display("FAIL cnt_sat got %0d exp %0d", evt_cnt, exp_cnt()); end
    checks++; if (pend !== 8'h01 || ovf !== 1'b0) begin errors++; $display("FAIL cnt_pend got %h/%b exp 01/0", pend, ovf); end
  endtask

  task automatic test_reset_mid();
    code_in = 3'd3; code_vld = 1'b1;
    tick(); acc_total++;
    code_vld = 1'b0;
    checks++; if (onehot_vld !== 1'b1 || onehot_out !== 8'h08) begin errors++; $display("FAIL mid_pulse got %b/%h exp 1/08", onehot_vld, onehot_out); end
    #2 rst_n = 1'b0;
    #1;
    acc_total = 0;
    checks++; if (onehot_vld !== 1'b0 || onehot_out !== 8'h00) begin errors++; $display("FAIL mid_rst_pulse got %b/%h exp 0/00", onehot_vld, onehot_out); end
    checks++; if (pend !== 8'h00 || ovf !== 1'b0 || code_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_state got %h/%b/%b exp 00/0/1", pend, ovf, code_rdy); end
    checks++; if (evt_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d exp 0", evt_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (onehot_vld !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL post_rst got %b/%h exp 0/00", onehot_vld, pend); end
  endtask

  initial begin
    checks = 0; errors = 0; acc_total = 0;
    rst_n = 1'b0; code_in = 3'd0; code_vld = 1'b0; clr = 8'h00; ovf_clr = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single();
    test_back_to_back();
    test_full_clear();
    test_overflow();
    test_ovf_priority();
    test_counter();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
